// File: rtl/fmm_reduce_acc_mod.sv
// rtl/fmm_reduce_acc_mod.sv - frame accumulator with bit-serial modular reduction
//
// Sums a frame of signed PROD_W-bit products into a signed ACC_W-bit
// accumulator, then reduces the sum modulo an unsigned MOD_W-bit modulus
// with a restoring shift/subtract loop (one accumulator bit per cycle).
//
// Ports:
//   ap_clk, ap_rst_n       clock, synchronous active-low reset
//   modulus                q, latched on the first beat of each frame
//   in_valid/in_ready      product stream handshake
//   in_data, in_last       product beat and end-of-frame marker
//   out_valid/out_ready    result handshake
//   out_data, out_err      reduced sum in [0, q-1]; error for q == 0 or over-length frame
//   busy                   frame in progress or result pending
module fmm_reduce_acc_mod #(
  parameter int PROD_W    = 62,
  parameter int ACC_W     = 72,
  parameter int MOD_W     = 31,
  parameter int MAX_BEATS = 1024
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [MOD_W-1:0]  modulus,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  out_data,
  output logic              out_err,
  output logic              busy
);

  localparam int CNT_W = 11;
  localparam int IDX_W = $clog2(ACC_W);

  typedef enum logic [1:0] {S_ACCUM, S_REDUCE, S_FIXUP, S_OUT} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [MOD_W-1:0]   r_q;
  logic [MOD_W:0]     r_r;
  logic [IDX_W-1:0]   r_idx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [MOD_W-1:0]   r_out_data;
  logic               r_out_err;

  logic [ACC_W-1:0]   w_in_ext;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_first;
  logic [ACC_W-1:0]   w_mag;
  logic [MOD_W:0]     w_trial;
  logic               w_ge;
  logic [MOD_W:0]     w_rsub;
  logic [MOD_W-1:0]   w_fix;
  logic               w_err;

  assign w_first    = (r_beat_cnt == '0);
  assign w_in_ext   = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
  // First beat of a frame replaces the accumulator instead of adding to it.
  assign w_acc_next = w_first ? w_in_ext : (r_acc + w_in_ext);

  // Magnitude of the held sum; the most negative value maps onto 2^(ACC_W-1),
  // which is still correct when read as unsigned.
  assign w_mag   = r_acc[ACC_W-1] ? (ACC_W'(0) - r_acc) : r_acc;

  // r < q < 2^MOD_W, so the shifted trial value fits in MOD_W+1 bits and
  // at most one subtraction restores it below q.
  assign w_trial = {r_r[MOD_W-1:0], w_mag[r_idx]};
  assign w_ge    = (w_trial >= {1'b0, r_q});
  assign w_rsub  = w_trial - {1'b0, r_q};

  // Negative sums fold back into [0, q-1]; a zero remainder stays zero.
  always_comb begin
    w_fix = r_r[MOD_W-1:0];
    if (r_q == '0)
      w_fix = '0;
    else if (r_acc[ACC_W-1] && (r_r != '0))
      w_fix = r_q - r_r[MOD_W-1:0];
  end

  assign w_err = (r_q == '0) | (r_beat_cnt > CNT_W'(MAX_BEATS));

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_acc <= w_acc_next;
            if (w_first)
              r_q <= modulus;
            if (r_beat_cnt != '1)
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (in_last) begin
              r_state    <= S_REDUCE;
              r_in_ready <= 1'b0;
              r_r        <= '0;
              r_idx      <= IDX_W'(ACC_W-1);
            end
          end
        end
        S_REDUCE: begin
          r_r <= w_ge ? w_rsub : w_trial;
          if (r_idx == '0)
            r_state <= S_FIXUP;
          else
            r_idx <= r_idx - IDX_W'(1);
        end
        S_FIXUP: begin
          r_out_data  <= w_fix;
          r_out_err   <= w_err;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign busy      = (r_state != S_ACCUM) | (r_beat_cnt != '0);

endmodule

// File: tb/tb_fmm_reduce_acc_mod.sv
// tb/tb_fmm_reduce_acc_mod.sv - directed self-checking bench for fmm_reduce_acc_mod
module tb_fmm_reduce_acc_mod;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [30:0] modulus;
  logic        in_valid;
  logic        in_ready;
  logic [61:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic        out_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int mon_n = 0;
  int mon_nvalid = 0;
  int mon_vcyc = -1;
  int mon_hs = -1;
  logic [30:0] mon_data = '0;
  logic        mon_err = 1'b0;
  logic        mon_prev = 1'b0;

  fmm_reduce_acc_mod dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .modulus   (modulus),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Edge counter and output-handshake recorder; values read here are the
  // ones present just before the edge.
  always @(posedge ap_clk) begin
    cyc = cyc + 1;
    if (out_valid && !mon_prev) begin
      mon_vcyc = cyc - 1;
      mon_nvalid = mon_nvalid + 1;
    end
    mon_prev = out_valid;
    if (out_valid && out_ready) begin
      mon_n = mon_n + 1;
      mon_data = out_data;
      mon_err = out_err;
      mon_hs = cyc;
    end
  end

  // Presents one beat at a negedge and holds it until accepted; returns the
  // accepting edge number, or -1 if never accepted.
  task automatic drive_beat(input logic [61:0] d, input logic last, output int acc_cyc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc_cyc  = -1;
    for (int t = 0; t < 400; t++) begin
      if (in_ready) begin
        @(posedge ap_clk);
        @(negedge ap_clk);
        acc_cyc = cyc;
        break;
      end
      @(negedge ap_clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int n0, output logic got);
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (mon_n != n0) begin
        got = 1'b1;
        break;
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_reset;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    modulus   = '0;
    repeat (3) @(negedge ap_clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 31'd0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_pos;
    int k; int n0; logic got;
    modulus = 31'd7;
    n0 = mon_n;
    drive_beat(62'd100, 1'b1, k);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pos_busy: got %b want 1", busy); end
    wait_out(n0, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL pos_timeout: got %b want 1", got); end
    n_cmp++; if (mon_data !== 31'd2) begin n_bad++; $display("FAIL pos_data: got %0d want 2", mon_data); end
    n_cmp++; if (mon_err !== 1'b0) begin n_bad++; $display("FAIL pos_err: got %b want 0", mon_err); end
    n_cmp++; if (mon_vcyc - k !== 73) begin n_bad++; $display("FAIL pos_latency: got %0d want 73", mon_vcyc - k); end
  endtask

  task automatic test_negative;
    int k; int n0; logic got;
    modulus = 31'd7;
    n0 = mon_n;
    drive_beat(-62'sd100, 1'b1, k);
    wait_out(n0, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL neg_timeout: got %b want 1", got); end
    n_cmp++; if (mon_data !== 31'd5) begin n_bad++; $display("FAIL neg_data: got %0d want 5", mon_data); end
    n0 = mon_n;
    drive_beat(62'd7, 1'b0, k);
    drive_beat(-62'sd14, 1'b1, k);
    wait_out(n0, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL negzero_timeout: got %b want 1", got); end
    n_cmp++; if (mon_data !== 31'd0) begin n_bad++; $display("FAIL negzero_data: got %0d want 0", mon_data); end
  endtask

  task automatic test_back_to_back;
    int k; int k2; int n0; logic got;
    out_ready = 1'b1;
    modulus = 31'h7FFF_FFFF;
    n0 = mon_n;
    for (int i = 0; i < 3; i++)
      drive_beat(62'h1FFF_FFFF_FFFF_FFFF, (i == 2), k);
    modulus = 31'd7;
    drive_beat(62'd100, 1'b1, k2);
    n_cmp++; if (mon_n !== n0 + 1) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", mon_n, n0 + 1); end
    n_cmp++; if (mon_data !== 31'h3FFF_FFFE) begin n_bad++; $display("FAIL big_data: got %0h want 3ffffffe", mon_data); end
    n_cmp++; if (mon_err !== 1'b0) begin n_bad++; $display("FAIL big_err: got %b want 0", mon_err); end
    n_cmp++; if (k2 !== mon_hs + 1) begin n_bad++; $display("FAIL b2b_accept: got %0d want %0d", k2, mon_hs + 1); end
    wait_out(n0 + 1, got);
    n_cmp++; if (mon_data !== 31'd2) begin n_bad++; $display("FAIL b2b_second: got %0d want 2", mon_data); end
  endtask

  task automatic test_backpressure;
    int k; int m; int n0; logic got;
    out_ready = 1'b0;
    modulus = 31'd7;
    n0 = mon_n;
    drive_beat(62'd100, 1'b1, k);
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge ap_clk);
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout: got %b want 1", got); end
    in_valid = 1'b1;
    in_data  = 62'd3;
    in_last  = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge ap_clk);
      n_cmp++; if (out_data !== 31'd2 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %0d/%b want 2/1", out_data, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    end
    n_cmp++; if (mon_n !== n0) begin n_bad++; $display("FAIL bp_early_hs: got %0d want %0d", mon_n, n0); end
    out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    m = cyc;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
    n_cmp++; if (mon_data !== 31'd2) begin n_bad++; $display("FAIL bp_data: got %0d want 2", mon_data); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_pending_taken: got %b want 1", busy); end
    wait_out(n0 + 1, got);
    n_cmp++; if (mon_data !== 31'd3) begin n_bad++; $display("FAIL bp_pending_data: got %0d want 3", mon_data); end
    n_cmp++; if (mon_vcyc !== m + 1 + 73) begin n_bad++; $display("FAIL bp_pending_lat: got %0d want %0d", mon_vcyc, m + 74); end
    // modulus change mid-frame must not be used: 15 mod 7 = 1, 15 mod 5 = 0
    modulus = 31'd7;
    n0 = mon_n;
    drive_beat(62'd10, 1'b0, k);
    modulus = 31'd5;
    drive_beat(62'd5, 1'b1, k);
    wait_out(n0, got);
    n_cmp++; if (mon_data !== 31'd1) begin n_bad++; $display("FAIL midmod_data: got %0d want 1", mon_data); end
  endtask

  task automatic test_errors;
    int k; int n0; int miss; logic got;
    modulus = 31'd0;
    n0 = mon_n;
    drive_beat(62'd5, 1'b1, k);
    wait_out(n0, got);
    n_cmp++; if (mon_data !== 31'd0 || mon_err !== 1'b1) begin n_bad++; $display("FAIL q0: got %0d/%b want 0/1", mon_data, mon_err); end
    modulus = 31'd1000;
    miss = 0;
    n0 = mon_n;
    for (int i = 0; i < 1025; i++) begin
      drive_beat(62'd1, (i == 1024), k);
      if (k < 0) miss++;
    end
    wait_out(n0, got);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL long_accept: got %0d want 0", miss); end
    n_cmp++; if (mon_data !== 31'd25 || mon_err !== 1'b1) begin n_bad++; $display("FAIL long_1025: got %0d/%b want 25/1", mon_data, mon_err); end
    miss = 0;
    n0 = mon_n;
    for (int i = 0; i < 1024; i++) begin
      drive_beat(62'd1, (i == 1023), k);
      if (k < 0) miss++;
    end
    wait_out(n0, got);
    n_cmp++; if (mon_data !== 31'd24 || mon_err !== 1'b0) begin n_bad++; $display("FAIL long_1024: got %0d/%b want 24/0", mon_data, mon_err); end
  endtask

  task automatic test_reset_mid_reduce;
    int k; int n0; int nv; logic got;
    modulus = 31'd7;
    drive_beat(62'd100, 1'b1, k);
    while (cyc < k + 29) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    nv = mon_nvalid;
    repeat (100) @(negedge ap_clk);
    n_cmp++; if (mon_nvalid !== nv || out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_output: got %0d want %0d", mon_nvalid, nv); end
    n0 = mon_n;
    drive_beat(62'd100, 1'b1, k);
    wait_out(n0, got);
    n_cmp++; if (mon_data !== 31'd2) begin n_bad++; $display("FAIL abort_next_data: got %0d want 2", mon_data); end
    n_cmp++; if (mon_vcyc - k !== 73) begin n_bad++; $display("FAIL abort_next_lat: got %0d want 73", mon_vcyc - k); end
  endtask

  initial begin
    test_reset();
    test_single_pos();
    test_negative();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid_reduce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
